// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the execute-stage shift/normalize sequencer.
// Holds the opcode and FSM state enumerations and the datapath widths.
package shift_seq_pkg;

    localparam int SEQ_W     = 8;
    localparam int SEQ_CNT_W = 4;

    // Opcode value 3'b111 is left undefined: it passes the operand through.
    typedef enum logic [2:0] {
        SLG  = 3'd0,
        SRG  = 3'd1,
        SLO  = 3'd2,
        SRO  = 3'd3,
        NEG  = 3'd4,
        RLZ  = 3'd5,
        CLRL = 3'd6
    } seq_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift/normalize sequencer beside the execute ALU.
// Runs linked shifts (SLG/SRG/SLO/SRO), iterated leading-zero normalize
// (RLZ) and negate (NEG).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   seq_op, operand   opcode and source value, captured with start
//   busy              high in EXEC and DONE
//   done              one-cycle completion pulse
//   result, shamt     result and RLZ shift count, held until next completion
//   link              saved-bit register chaining multi-word shifts
//   zero              result == 0, registered with result
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int W     = SEQ_W,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       seq_op,
    input  logic [W-1:0]     operand,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic [CNT_W-1:0] shamt,
    output logic             link,
    output logic             zero
);

    seq_state_t       state_q, state_d;
    seq_op_t          op_q, op_d;
    logic [W-1:0]     work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W-1:0]     result_q;
    logic [CNT_W-1:0] shamt_q;
    logic             link_q;
    logic             zero_q;

    // Values to commit on the EXEC->DONE edge.
    logic             fin;
    logic [W-1:0]     res_d;
    logic [CNT_W-1:0] shamt_d;
    logic             link_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        fin     = 1'b0;
        res_d   = work_q;
        shamt_d = '0;
        link_d  = link_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = seq_op_t'(seq_op);
                    work_d  = operand;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                fin     = 1'b1;
                state_d = DONE;
                case (op_q)
                    SLG: begin
                        res_d  = {work_q[W-2:0], 1'b0};
                        link_d = work_q[W-1];
                    end
                    SRG: begin
                        res_d  = {1'b0, work_q[W-1:1]};
                        link_d = work_q[0];
                    end
                    // Linked shifts read link before this op updates it.
                    SLO: begin
                        res_d  = {work_q[W-2:0], link_q};
                        link_d = work_q[W-1];
                    end
                    SRO: begin
                        res_d  = {link_q, work_q[W-1:1]};
                        link_d = work_q[0];
                    end
                    NEG: begin
                        res_d = (~work_q) + W'(1);
                    end
                    CLRL: begin
                        link_d = 1'b0;
                    end
                    // One shift per cycle until the MSB is set; a zero
                    // operand finishes at once with the full-width count.
                    // A nonzero operand needs at most W-1 shifts, so cnt
                    // never exceeds W-1.
                    RLZ: begin
                        unique case (1'b1)
                            work_q[W-1]: begin
                                shamt_d = cnt_q;
                            end
                            (work_q == '0): begin
                                res_d   = '0;
                                shamt_d = CNT_W'(W);
                            end
                            default: begin
                                fin     = 1'b0;
                                state_d = EXEC;
                                work_d  = {work_q[W-2:0], 1'b0};
                                cnt_d   = cnt_q + CNT_W'(1);
                            end
                        endcase
                    end
                    default: begin
                        res_d = work_q;
                    end
                endcase
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= SLG;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            shamt_q  <= '0;
            link_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            if (fin) begin
                result_q <= res_d;
                shamt_q  <= shamt_d;
                link_q   <= link_d;
                zero_q   <= (res_d == '0);
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign shamt  = shamt_q;
    assign link   = link_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed vector table, multi-cycle
// corner sequences, and random ops against an arithmetic reference model.
module tb_shift_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] seq_op;
    logic [7:0] operand;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] shamt;
    logic       link;
    logic       zero;

    int tests = 0;
    int fails = 0;

    shift_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .seq_op  (seq_op),
        .operand (operand),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .shamt   (shamt),
        .link    (link),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] r;
        logic       l;
        logic [3:0] s;
        logic       z;
        int         cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: results from the op definitions with plain arithmetic.
    task automatic model(input int op, input int a, input int lin,
                         output int r, output int l, output int s,
                         output int z, output int cyc);
        int msb;
        r = a; l = lin; s = 0; cyc = 2;
        case (op)
            0: begin r = (a * 2) % 256; l = a / 128; end
            1: begin r = a / 2; l = a % 2; end
            2: begin r = (a * 2) % 256 + lin; l = a / 128; end
            3: begin r = a / 2 + lin * 128; l = a % 2; end
            4: r = (256 - a) % 256;
            5: begin
                if (a == 0) begin
                    r = 0; s = 8;
                end else begin
                    msb = 0;
                    for (int i = 0; i < 8; i++)
                        if ((a >> i) % 2 == 1) msb = i;
                    s = 7 - msb;
                    r = (a << s) % 256;
                    cyc = 2 + s;
                end
            end
            6: l = 0;
            default: r = a;
        endcase
        z = (r == 0) ? 1 : 0;
    endtask

    // Issue one op and wait for done; cyc counts cycles from the START
    // edge to the cycle where done is seen (bounded).
    task automatic do_op(input logic [2:0] op, input logic [7:0] a,
                         output int cyc, output bit held,
                         output bit after);
        logic [7:0] prev;
        prev = result;
        @(negedge clk);
        start = 1'b1; seq_op = op; operand = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        seq_op = 3'($urandom);
        operand = 8'($urandom);
        cyc = 0;
        held = 1'b1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (!busy || result !== prev) held = 1'b0;
        end
        after = 1'b0;
        if (done) begin
            @(negedge clk);
            after = busy | done;
        end
    endtask

    int  mlink;
    int  er, el, es, ez, ec;
    int  cyc;
    bit  held, after;
    int  dones;
    logic [2:0] rop;
    logic [7:0] ra;

    initial begin
        reset = 1'b1; start = 1'b0; seq_op = '0; operand = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_shamt", shamt, 0);
        chk("rst_link", link, 0);
        chk("rst_zero", zero, 0);
        reset = 1'b0;

        vecs.push_back('{3'd0, 8'hA5, 8'h4A, 1, 0, 0, 2});
        vecs.push_back('{3'd0, 8'h80, 8'h00, 1, 0, 1, 2});
        vecs.push_back('{3'd2, 8'h01, 8'h03, 0, 0, 0, 2});
        vecs.push_back('{3'd1, 8'h01, 8'h00, 1, 0, 1, 2});
        vecs.push_back('{3'd3, 8'h00, 8'h80, 0, 0, 0, 2});
        vecs.push_back('{3'd5, 8'h01, 8'h80, 0, 7, 0, 9});
        vecs.push_back('{3'd5, 8'h00, 8'h00, 0, 8, 1, 2});
        vecs.push_back('{3'd5, 8'hC0, 8'hC0, 0, 0, 0, 2});
        vecs.push_back('{3'd4, 8'h01, 8'hFF, 0, 0, 0, 2});
        vecs.push_back('{3'd4, 8'h80, 8'h80, 0, 0, 0, 2});
        vecs.push_back('{3'd4, 8'h00, 8'h00, 0, 0, 1, 2});
        vecs.push_back('{3'd0, 8'hFF, 8'hFE, 1, 0, 0, 2});
        vecs.push_back('{3'd6, 8'h5A, 8'h5A, 0, 0, 0, 2});
        vecs.push_back('{3'd7, 8'h3C, 8'h3C, 0, 0, 0, 2});
        vecs.push_back('{3'd3, 8'h81, 8'h40, 1, 0, 0, 2});
        vecs.push_back('{3'd4, 8'h7F, 8'h81, 1, 0, 0, 2});
        vecs.push_back('{3'd5, 8'h10, 8'h80, 1, 3, 0, 5});
        vecs.push_back('{3'd7, 8'h00, 8'h00, 1, 0, 1, 2});

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, cyc, held, after);
            chk($sformatf("v%0d_result", i), result, vecs[i].r);
            chk($sformatf("v%0d_link", i), link, vecs[i].l);
            chk($sformatf("v%0d_shamt", i), shamt, vecs[i].s);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
            chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("v%0d_held", i), held, 1);
            chk($sformatf("v%0d_pulse", i), after, 0);
        end
        mlink = 1;

        // Reset three cycles into a long RLZ, with link and result set.
        do_op(3'd0, 8'h81, cyc, held, after);
        chk("pre_rst_link", link, 1);
        @(negedge clk);
        start = 1'b1; seq_op = 3'd5; operand = 8'h01;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_out", {result, shamt, link, zero}, 0);
        reset = 1'b0;
        mlink = 0;

        // START pulses in EXEC and DONE must be ignored.
        dones = 0;
        @(negedge clk);
        start = 1'b1; seq_op = 3'd0; operand = 8'h01;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        dones += int'(done);
        start = 1'b1; seq_op = 3'd4; operand = 8'h55;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        dones += int'(done);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            dones += int'(done);
        end
        chk("ign_dones", dones, 1);
        chk("ign_result", result, 8'h02);
        chk("ign_busy", busy, 0);

        // Random ops against the model; link chains across ops.
        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 7);
            model(int'(rop), int'(ra), mlink, er, el, es, ez, ec);
            do_op(rop, ra, cyc, held, after);
            chk($sformatf("r%0d_op%0d_%0h_result", n, rop, ra), result, er);
            chk($sformatf("r%0d_link", n), link, el);
            chk($sformatf("r%0d_shamt", n), shamt, es);
            chk($sformatf("r%0d_zero", n), zero, ez);
            chk($sformatf("r%0d_cycles", n), cyc, ec);
            mlink = el;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
